// File: rtl/cgra_lsu_arbiter_pkg.sv
// cgra_lsu_pkg: shared constants and PE index type for the CGRA load/store arbiter
package cgra_lsu_pkg;
  localparam int NB_ROWS_DEF = 4;
  localparam int NB_COLS_DEF = 4;
  localparam int NB_PE       = NB_ROWS_DEF * NB_COLS_DEF;
  localparam int ADDR_W_DEF  = 12;
  localparam int PE_IDX_W    = (NB_PE > 1) ? $clog2(NB_PE) : 1;
  typedef logic [PE_IDX_W-1:0] pe_idx_t;
endpackage

// File: rtl/cgra_lsu_arbiter_if.sv
// cgra_lsu_arbiter_if: PE-side request/response and memory-side bus of the LSU arbiter
interface cgra_lsu_arbiter_if
  import cgra_lsu_pkg::*;
#(
  parameter int NB_PE_P = NB_PE,
  parameter int ADDR_W  = ADDR_W_DEF
);
  logic [NB_PE_P-1:0]       pe_req_i;
  logic [NB_PE_P-1:0]       pe_we_i;
  logic [NB_PE_P-1:0][31:0] pe_addr_i;
  logic [NB_PE_P-1:0][31:0] pe_wdata_i;
  logic [NB_PE_P-1:0]       pe_gnt_o;
  logic [NB_PE_P-1:0]       pe_rvalid_o;
  logic [31:0]              pe_rdata_o;
  logic                     mem_req_o;
  logic                     mem_gnt_i;
  logic                     mem_we_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [31:0]              mem_wdata_o;
  logic [31:0]              mem_rdata_i;
  logic                     err_o;
  modport slave (
    input  pe_req_i, pe_we_i, pe_addr_i, pe_wdata_i, mem_gnt_i, mem_rdata_i,
    output pe_gnt_o, pe_rvalid_o, pe_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
  modport master (
    output pe_req_i, pe_we_i, pe_addr_i, pe_wdata_i, mem_gnt_i, mem_rdata_i,
    input  pe_gnt_o, pe_rvalid_o, pe_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/cgra_rr_arbiter.sv
// cgra_rr_arbiter: round-robin pick starting after the last grant, frozen while the memory stalls
module cgra_rr_arbiter #(
  parameter int NB_PE = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NB_PE-1:0] req_i,
  input  logic             stall_i,
  input  logic             advance_i,
  output logic [NB_PE-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);
  localparam logic [NB_PE-1:0] ONE = 1;
  logic [IDX_W-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, pick;
  logic             lock_q, lock_d, found;

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NB_PE);
  endfunction

  // search upward from ptr+1 with wrap; a stalled winner stays locked until it transfers
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NB_PE; k++)
      if (!found && req_i[wrap(int'(ptr_q) + 1 + k)]) begin
        pick  = wrap(int'(ptr_q) + 1 + k);
        found = 1'b1;
      end
    idx_o      = lock_q ? lock_idx_q : pick;
    valid_o    = lock_q | found;
    gnt_o      = valid_o ? ONE << idx_o : '0;
    ptr_d      = advance_i ? idx_o : ptr_q;
    lock_d     = stall_i;
    lock_idx_d = idx_o;
  end

  // pointer resets to the last PE so PE 0 has first priority
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q      <= IDX_W'(NB_PE - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
endmodule

// File: rtl/cgra_lsu_arbiter.sv
// cgra_lsu_arbiter: shares one data-memory port among the CGRA PEs; CGRA_LSU_ADDR_CHECK_EN enables out-of-range address trapping
module cgra_lsu_arbiter
  import cgra_lsu_pkg::*;
#(
  parameter int NB_ROWS = NB_ROWS_DEF,
  parameter int NB_COLS = NB_COLS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  cgra_lsu_arbiter_if.slave bus
);
  localparam int N     = NB_ROWS * NB_COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = 1;
  logic [N-1:0]     win_oh;
  logic [IDX_W-1:0] win_idx, ridx_q, ridx_d;
  logic             win_valid, win_bad, xfer, stall;
  logic             rv_q, rv_d, zero_q, zero_d, err_q, err_d;

  cgra_rr_arbiter #(.NB_PE(N), .IDX_W(IDX_W)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.pe_req_i),
    .stall_i  (stall),
    .advance_i(xfer),
    .gnt_o    (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

`ifdef CGRA_LSU_ADDR_CHECK_EN
  assign win_bad = win_valid & (|bus.pe_addr_i[win_idx][31:ADDR_W]);
`else
  assign win_bad = 1'b0;
`endif

  // out-of-range requests complete locally without touching memory
  always_comb begin
    bus.mem_req_o   = win_valid & ~win_bad;
    xfer            = win_valid & (win_bad | bus.mem_gnt_i);
    stall           = win_valid & ~xfer;
    bus.pe_gnt_o    = xfer ? win_oh : '0;
    bus.mem_we_o    = bus.pe_we_i[win_idx];
    bus.mem_addr_o  = bus.pe_addr_i[win_idx][ADDR_W-1:0];
    bus.mem_wdata_o = bus.pe_wdata_i[win_idx];
    rv_d            = xfer & ~bus.pe_we_i[win_idx];
    ridx_d          = win_idx;
    zero_d          = win_bad;
    err_d           = xfer & win_bad;
    bus.pe_rvalid_o = rv_q ? ONE << ridx_q : '0;
    bus.pe_rdata_o  = (rv_q & ~zero_q) ? bus.mem_rdata_i : '0;
    bus.err_o       = err_q;
  end

  // load response slot: memory data arrives one cycle after the accepting grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rv_q   <= 1'b0;
      ridx_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rv_q   <= rv_d;
      ridx_q <= ridx_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
endmodule
